// File: rtl/instr_stream_encoder_pkg.sv
// instr_stream_encoder_pkg
// Shared control constants: MIPS primary opcodes, R-type funct codes and the
// symbolic operation kinds accepted by the encoder. The pipeline control
// decoder imports the same constants, so encode and decode cannot drift apart.
package instr_stream_encoder_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_MUL   = 6'h18;

   // Kinds 11..15 are illegal.
   typedef enum logic [3:0] {
      KIND_ADD  = 4'd0,
      KIND_SUB  = 4'd1,
      KIND_AND  = 4'd2,
      KIND_OR   = 4'd3,
      KIND_MUL  = 4'd4,
      KIND_ADDI = 4'd5,
      KIND_LW   = 4'd6,
      KIND_SW   = 4'd7,
      KIND_BEQ  = 4'd8,
      KIND_ORI  = 4'd9,
      KIND_J    = 4'd10
   } op_kind_e;

endpackage

// File: rtl/instr_stream_encoder_if.sv
// instr_stream_encoder_if
// Symbolic-operation stream into the encoder.
//   op_valid  master->slave  operation present
//   op_ready  slave->master  encoder can accept
//   op_kind   master->slave  operation kind (op_kind_e, 11..15 illegal)
//   rs/rt/rd  master->slave  register fields
//   imm       master->slave  16-bit immediate (I-type)
//   target    master->slave  26-bit jump target (J)
//   last      master->slave  final operation of the program
interface instr_stream_encoder_if;
   logic        op_valid;
   logic        op_ready;
   logic [3:0]  op_kind;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [15:0] imm;
   logic [25:0] target;
   logic        last;

   modport master (output op_valid, op_kind, rs, rt, rd, imm, target, last,
                   input  op_ready);
   modport slave  (input  op_valid, op_kind, rs, rt, rd, imm, target, last,
                   output op_ready);
endinterface

// File: rtl/instr_stream_encoder_word_pack.sv
// instr_stream_encoder_word_pack
// Pure combinational packer: operation kind + fields -> 32-bit MIPS word.
//   op_kind         in   operation kind
//   rs/rt/rd        in   register fields
//   imm             in   I-type immediate
//   target          in   J-type target
//   word            out  encoded instruction (0 when illegal)
//   illegal         out  kind not recognised
// Fields a format does not use are ignored.
module instr_stream_encoder_word_pack
   import instr_stream_encoder_pkg::*;
(
   input  logic [3:0]  op_kind,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word,
   output logic        illegal
);

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (op_kind)
         KIND_ADD:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
         KIND_SUB:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
         KIND_AND:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
         KIND_OR:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
         KIND_MUL:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_MUL};
         KIND_ADDI: word = {OP_ADDI, rs, rt, imm};
         KIND_LW:   word = {OP_LW, rs, rt, imm};
         KIND_SW:   word = {OP_SW, rs, rt, imm};
         KIND_BEQ:  word = {OP_BEQ, rs, rt, imm};
         KIND_ORI:  word = {OP_ORI, rs, rt, imm};
         KIND_J:    word = {OP_J, target};
         default:   illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder
// Accepts symbolic operations over a valid/ready stream, packs each into a MIPS
// word and writes it to instruction memory starting at BASE_W after start_i.
//   clk_i       in   clock, rising edge
//   rst_i       in   asynchronous reset, active low
//   start_i     in   restart pulse: clear counter/flags, enter LOAD (highest priority)
//   op_if       -    operation stream (slave side)
//   mem_we_o    out  write strobe, one cycle after the accepting edge
//   mem_addr_o  out  word address of the write
//   mem_data_o  out  encoded word
//   count_o     out  words written since start_i
//   done_o      out  program loaded (level until start_i)
//   err_o       out  sticky: illegal kind seen
//   ovf_o       out  sticky: capacity reached without last
// Build option INSTR_STREAM_NOP_PAD_EN: after a program ends on last, four NOP
// words (32'h0) follow, stopping early at capacity.
//
// state | meaning
// IDLE  | after reset, waiting for start_i
// LOAD  | accepting operations
// PAD   | writing trailing NOPs (INSTR_STREAM_NOP_PAD_EN only)
// DONE  | program loaded, waiting for start_i
module instr_stream_encoder
   import instr_stream_encoder_pkg::*;
#(
   parameter int                ADDR_W = 8,
   parameter logic [ADDR_W-1:0] BASE_W = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   instr_stream_encoder_if.slave op_if,
   output logic                  mem_we_o,
   output logic [ADDR_W-1:0]     mem_addr_o,
   output logic [31:0]           mem_data_o,
   output logic [ADDR_W:0]       count_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic                  ovf_o
);

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

`ifdef INSTR_STREAM_NOP_PAD_EN
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PAD, ST_DONE} state_e;
   logic [1:0] pad_q;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_e;
`endif

   state_e            state_q, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W:0]   count_inc;
   logic              accept, cap_hit;
   logic              wr_en, set_err, set_ovf;
   logic [31:0]       wr_data;
   logic [31:0]       pack_word;
   logic              pack_illegal;

   instr_stream_encoder_word_pack u_pack (
      .op_kind (op_if.op_kind),
      .rs      (op_if.rs),
      .rt      (op_if.rt),
      .rd      (op_if.rd),
      .imm     (op_if.imm),
      .target  (op_if.target),
      .word    (pack_word),
      .illegal (pack_illegal)
   );

   assign op_if.op_ready = (state_q == ST_LOAD) && !start_i;
   assign accept         = op_if.op_valid && op_if.op_ready;
   assign count_inc      = count_o + 1'b1;
   assign cap_hit        = (count_inc == DEPTH);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= ST_IDLE;
      else        state_q <= state_nxt;
   end

   // Where a program that ends on last goes next.
`ifdef INSTR_STREAM_NOP_PAD_EN
   localparam state_e ST_END = ST_PAD;
`else
   localparam state_e ST_END = ST_DONE;
`endif

   always_comb begin
      state_nxt = state_q;
      wr_en     = 1'b0;
      wr_data   = pack_word;
      set_err   = 1'b0;
      set_ovf   = 1'b0;
      if (start_i) begin
         state_nxt = ST_LOAD;
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (accept) begin
                  if (pack_illegal) begin
                     set_err = 1'b1;
                     if (op_if.last) state_nxt = ST_END;
                  end else begin
                     wr_en = 1'b1;
                     // Memory full takes precedence over padding.
                     if (cap_hit) begin
                        state_nxt = ST_DONE;
                        set_ovf   = !op_if.last;
                     end else if (op_if.last) begin
                        state_nxt = ST_END;
                     end
                  end
               end
            end
`ifdef INSTR_STREAM_NOP_PAD_EN
            ST_PAD: begin
               wr_en   = 1'b1;
               wr_data = '0;
               if (cap_hit || pad_q == 2'd3) state_nxt = ST_DONE;
            end
`endif
            default: ;
         endcase
      end
   end

   // wr_en is already gated by start_i, so a write registered on the previous
   // edge still appears while the counter restarts.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mem_we_o   <= 1'b0;
         mem_addr_o <= BASE_W;
         mem_data_o <= '0;
         addr_q     <= BASE_W;
         count_o    <= '0;
         done_o     <= 1'b0;
         err_o      <= 1'b0;
         ovf_o      <= 1'b0;
      end else begin
         mem_we_o <= wr_en;
         if (start_i) begin
            addr_q  <= BASE_W;
            count_o <= '0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
            ovf_o   <= 1'b0;
         end else begin
            if (wr_en) begin
               mem_addr_o <= addr_q;
               mem_data_o <= wr_data;
               addr_q     <= addr_q + 1'b1;
               count_o    <= count_inc;
            end
            if (set_err)             err_o  <= 1'b1;
            if (set_ovf)             ovf_o  <= 1'b1;
            if (state_q == ST_DONE)  done_o <= 1'b1;
         end
      end
   end

`ifdef INSTR_STREAM_NOP_PAD_EN
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                                pad_q <= '0;
      else if (!start_i && state_q == ST_PAD)    pad_q <= pad_q + 1'b1;
      else                                       pad_q <= '0;
   end
`endif

endmodule
